serialize_lanes: RTL and testbench

- Downstream companion to the single-entry DTI register stage.
- Accepts one wide DTI word carrying up to LANES lanes plus a lane-count field, and emits the valid lanes one per transfer on a narrow DTI output. The last lane of each word is tagged.
- Sits between a wide datapath (after the register stage) and a narrow consumer.
- Sustains full throughput: a new word is accepted in the same cycle its last lane is handed off.

---
 rtl/serialize_lanes_if.sv | 12 +
 rtl/serialize_lanes.sv | 86 ++++++++
 tb/tb_serialize_lanes.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/serialize_lanes_if.sv
// Valid/ready word channel shared by the wide input and the narrow lane output.
// The master drives valid/data and the slave drives ready.
interface serialize_lanes_if #(
    parameter int W = 8
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/serialize_lanes.sv
// Splits one wide word of up to LANES lanes into single-lane transfers.
// The last lane of each word is tagged with eot.
module serialize_lanes #(
    parameter int LANE_W = 8,
    parameter int LANES  = 4,
    parameter int CNT_W  = $clog2(LANES)
) (
    input  logic               clk,
    input  logic               rst,
    serialize_lanes_if.slave   din_i,
    serialize_lanes_if.master  dout_o
);
    localparam int               WORD_W  = LANES * LANE_W + CNT_W;
    localparam logic [CNT_W-1:0] TOP_IDX = CNT_W'(LANES - 1);

    if ($size(din_i.data) != WORD_W) begin : gen_din_width_err
        $error("serialize_lanes: din data width must be LANES*LANE_W+CNT_W");
    end
    if ($size(dout_o.data) != LANE_W + 1) begin : gen_dout_width_err
        $error("serialize_lanes: dout data width must be LANE_W+1");
    end
    if (LANES < 2) begin : gen_lanes_err
        $error("serialize_lanes: LANES must be at least 2");
    end

    typedef enum logic {
        EMPTY,
        HOLD
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]  word_q, word_d;

    logic [LANE_W-1:0]  laneArr [LANES];
    logic [CNT_W-1:0]   lenM1;
    logic               full;
    logic               last;
    logic               accept;

    for (genvar g = 0; g < LANES; g++) begin : gen_lanes
        assign laneArr[g] = word_q[g*LANE_W +: LANE_W];
    end

    assign lenM1  = word_q[LANES*LANE_W +: CNT_W];
    assign full   = (state_q == HOLD);
    // Saturating at the top lane keeps an out-of-range len from walking idx past the word.
    assign last   = full && ((idx_q == lenM1) || (idx_q == TOP_IDX));
    assign accept = din_i.valid && din_i.ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
        word_q <= word_d;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        if (accept) begin
            word_d  = din_i.data;
            state_d = HOLD;
            idx_d   = '0;
        end else if (full && dout_o.ready) begin
            if (last) begin
                state_d = EMPTY;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Refilling on the last-lane handoff is what keeps back-to-back words bubble-free.
    always_comb begin
        din_i.ready  = !full || (last && dout_o.ready);
        dout_o.valid = full;
        dout_o.data  = {last, laneArr[idx_q]};
    end
endmodule

// File: tb/tb_serialize_lanes.sv
// Directed and random checks of serialize_lanes against a queue model that
// expands every accepted word into its expected lane transfers.
module tb_serialize_lanes;
    localparam int LANE_W = 8;
    localparam int LANES  = 4;
    localparam int IN_W   = LANES * LANE_W + 2;
    localparam int OUT_W  = LANE_W + 1;

    logic clk = 1'b0;
    logic rst;
    logic modelOn = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [OUT_W-1:0] expQ [$];
    logic             prevValid = 1'b0;
    logic             prevReady = 1'b0;
    logic             prevRst   = 1'b1;
    logic [OUT_W-1:0] prevData  = '0;

    serialize_lanes_if #(.W(IN_W))  dinIf ();
    serialize_lanes_if #(.W(OUT_W)) doutIf ();

    serialize_lanes #(
        .LANE_W (LANE_W),
        .LANES  (LANES)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .din_i  (dinIf),
        .dout_o (doutIf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [IN_W-1:0] mkWord(input logic [1:0] len, input logic [7:0] l3,
                                               input logic [7:0] l2, input logic [7:0] l1,
                                               input logic [7:0] l0);
        return {len, l3, l2, l1, l0};
    endfunction

    function automatic logic [IN_W-1:0] randWord();
        logic [IN_W-1:0] w;
        w = {$urandom(), $urandom()};
        return w;
    endfunction

    task automatic applyStimulus(input logic r, input logic v, input logic [IN_W-1:0] d,
                                 input logic rdy);
        rst          = r;
        dinIf.valid  = v;
        dinIf.data   = d;
        doutIf.ready = rdy;
    endtask

    task automatic runRow(input string name, input logic r, input logic v,
                          input logic [IN_W-1:0] d, input logic rdy, input logic ev,
                          input logic [OUT_W-1:0] ed, input logic er);
        applyStimulus(r, v, d, rdy);
        @(negedge clk);
        checkOutput({name, " valid"}, doutIf.valid, ev);
        if (ev) checkOutput({name, " data"}, doutIf.data, ed);
        checkOutput({name, " din ready"}, dinIf.ready, er);
        @(posedge clk);
        #1;
    endtask

    // Model: the queue holds exactly the lanes still owed for accepted words.
    always @(negedge clk) begin
        if (modelOn) begin
            if (expQ.size() > 0) begin
                checkOutput("model valid", doutIf.valid, 1);
                checkOutput("model data", doutIf.data, expQ[0]);
            end else begin
                checkOutput("model valid", doutIf.valid, 0);
            end
            checkOutput("model din ready", dinIf.ready,
                        (expQ.size() == 0) || (expQ.size() == 1 && doutIf.ready));
            if (prevValid && !prevReady && !prevRst) begin
                checkOutput("stall valid held", doutIf.valid, 1);
                checkOutput("stall data held", doutIf.data, prevData);
            end
            if (rst) begin
                expQ.delete();
            end else begin
                if (doutIf.valid && doutIf.ready && expQ.size() > 0) void'(expQ.pop_front());
                if (dinIf.valid && dinIf.ready) begin
                    int len;
                    len = int'(dinIf.data[IN_W-1 -: 2]);
                    assert (len < LANES) else $error("[TB] illegal lane count on din");
                    for (int i = 0; i <= len; i++)
                        expQ.push_back({(i == len), dinIf.data[i*LANE_W +: LANE_W]});
                end
            end
            prevValid = doutIf.valid;
            prevReady = doutIf.ready;
            prevData  = doutIf.data;
            prevRst   = rst;
        end
    end

    initial begin
        int sent;
        int cyc;
        logic [IN_W-1:0] w;
        logic v;
        logic [IN_W-1:0] wA, wB, wC, wD, wE, wF, wG, wH;

        wA = mkWord(2'd1, 8'hFF, 8'hFF, 8'hA1, 8'hA0);
        wB = mkWord(2'd2, 8'hFF, 8'hB2, 8'hB1, 8'hB0);
        wC = mkWord(2'd0, 8'hEE, 8'hEE, 8'hEE, 8'h5A);
        wD = mkWord(2'd1, 8'hEE, 8'hEE, 8'h77, 8'h66);
        wE = mkWord(2'd3, 8'h94, 8'h93, 8'h92, 8'h91);
        wF = mkWord(2'd1, 8'h00, 8'h00, 8'hC1, 8'hC0);
        wG = mkWord(2'd1, 8'h00, 8'h00, 8'hD1, 8'hD0);
        wH = mkWord(2'd3, 8'h13, 8'h12, 8'h11, 8'h10);

        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        modelOn = 1'b1;

        // Four-lane word, then drain
        runRow("t1 r0", 0, 1, mkWord(2'd3, 8'h44, 8'h33, 8'h22, 8'h11), 1, 0, 9'h000, 1);
        runRow("t1 r1", 0, 0, '0, 1, 1, 9'h011, 0);
        runRow("t1 r2", 0, 0, '0, 1, 1, 9'h022, 0);
        runRow("t1 r3", 0, 0, '0, 1, 1, 9'h033, 0);
        runRow("t1 r4", 0, 0, '0, 1, 1, 9'h144, 1);
        runRow("t1 r5", 0, 0, '0, 1, 0, 9'h000, 1);

        runRow("t2 r0", 0, 1, wA, 1, 0, 9'h000, 1);
        runRow("t2 r1", 0, 1, wB, 1, 1, 9'h0A0, 0);
        runRow("t2 r2", 0, 1, wB, 1, 1, 9'h1A1, 1);
        runRow("t2 r3", 0, 0, '0, 1, 1, 9'h0B0, 0);
        runRow("t2 r4", 0, 0, '0, 1, 1, 9'h0B1, 0);
        runRow("t2 r5", 0, 0, '0, 1, 1, 9'h1B2, 1);
        runRow("t2 r6", 0, 0, '0, 1, 0, 9'h000, 1);

        runRow("t3 r0", 0, 1, wC, 1, 0, 9'h000, 1);
        runRow("t3 r1", 0, 1, wD, 1, 1, 9'h15A, 1);
        runRow("t3 r2", 0, 0, '0, 1, 1, 9'h066, 0);
        runRow("t3 r3", 0, 0, '0, 1, 1, 9'h177, 1);
        runRow("t3 r4", 0, 0, '0, 1, 0, 9'h000, 1);

        // Random words against random output stalls
        sent = 0;
        cyc  = 0;
        w    = randWord();
        while (sent < 200 && cyc < 5000) begin
            v = ($urandom_range(0, 3) != 0);
            applyStimulus(1'b0, v, w, 1'($urandom_range(0, 1)));
            @(negedge clk);
            if (v && dinIf.ready) begin
                sent++;
                w = randWord();
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("t4 words sent", sent, 200);
        for (int i = 0; i < 40 && expQ.size() != 0; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
            @(posedge clk);
            #1;
        end
        checkOutput("t4 drained", expQ.size(), 0);

        runRow("t5 r0", 0, 1, wE, 1, 0, 9'h000, 1);
        runRow("t5 r1", 0, 0, '0, 1, 1, 9'h091, 0);
        runRow("t5 r2", 0, 0, '0, 1, 1, 9'h092, 0);
        runRow("t5 r3", 1, 1, wF, 1, 1, 9'h093, 0);
        runRow("t5 r4", 0, 0, '0, 1, 0, 9'h000, 1);
        runRow("t5 r5", 0, 1, wF, 1, 0, 9'h000, 1);
        runRow("t5 r6", 0, 0, '0, 1, 1, 9'h0C0, 0);
        runRow("t5 r7", 0, 0, '0, 1, 1, 9'h1C1, 1);
        runRow("t5 r8", 0, 0, '0, 1, 0, 9'h000, 1);

        runRow("t6 accept", 0, 1, wG, 0, 0, 9'h000, 1);
        for (int i = 0; i < 10; i++)
            runRow("t6 hold", 0, 1, wH, 0, 1, 9'h0D0, 0);
        runRow("t6 r11", 0, 0, '0, 1, 1, 9'h0D0, 0);
        runRow("t6 r12", 0, 0, '0, 1, 1, 9'h1D1, 1);
        runRow("t6 r13", 0, 0, '0, 1, 0, 9'h000, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
